gen_reg_arbiter: RTL

Round-robin arbiter that shares the single access port of the six-entry 20-bit general register file between NREQ requesters (e.g. fetch/decode read, ALU writeback, load unit). Each requester presents a full transaction: read/write, access width, register index, write data. The arbiter grants one at a time, sequences the register-file port, and returns a one-cycle ack with read data or an error flag. It sits between the execution units and the register file.

---
 rtl/gen_reg_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gen_reg_arbiter.sv
// ---------------------------------------------------------------------------
// gen_reg_arbiter
//
// Shares the single access port of the six-entry general register file
// between NREQ requesters. Each requester presents a complete transaction
// (op, access width, index, write data) and holds it until its ack.
// Requesters are granted one at a time in round-robin order. The arbiter
// drives the register-file port and returns a one-cycle ack. The ack carries
// read data, or err when the transaction is rejected.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   req[NREQ]     per-requester request level
//   we[NREQ]      per-requester op (1 write, 0 read)
//   sel[2*NREQ]   per-requester access width (00 full, 01 high, 10 low, 11 bad)
//   idx, wdata    per-requester register index / write data, packed by requester
//   ack[NREQ]     one-cycle completion pulse, one-hot or zero
//   err           qualifies ack: transaction rejected
//   rdata         read result, valid with the ack of a read
//   busy          high whenever a transaction is in flight
//   rf_*          registered register-file port; rf_rdata returns a cycle after rf_en
// ---------------------------------------------------------------------------
module gen_reg_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 20,
    parameter int IDX_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [2*NREQ-1:0]      sel,
    input  logic [IDX_W*NREQ-1:0]  idx,
    input  logic [DATA_W*NREQ-1:0] wdata,
    output logic [NREQ-1:0]        ack,
    output logic                   err,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic                   rf_en,
    output logic                   rf_we,
    output logic [1:0]             rf_addr_sel,
    output logic [IDX_W-1:0]       rf_addr,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [DATA_W-1:0]      rf_rdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(5);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   g_q, g_d;
    logic               err_q, err_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rf_en_q, rf_en_d;
    logic               rf_we_q, rf_we_d;
    logic [1:0]         sel_q, sel_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    // Round-robin scan: rotate req so the pointer sits at bit 0, take the
    // lowest set bit, then map the offset back to a requester number.
    logic [2*NREQ-1:0]  req_dbl;
    logic [NREQ-1:0]    req_rot;
    logic               found;
    logic [PTR_W-1:0]   off;
    logic [PTR_W:0]     win_sum;
    logic [PTR_W-1:0]   win;
    logic               win_we;
    logic [1:0]         win_sel;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_legal;

    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned; that is what keeps latches out.
    always_comb begin
        req_dbl   = {req, req} >> ptr_q;
        req_rot   = req_dbl[NREQ-1:0];
        found     = 1'b0;
        off       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                off   = PTR_W'(i);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, off};
        if (win_sum >= (PTR_W+1)'(NREQ)) begin
            win_sum = win_sum - (PTR_W+1)'(NREQ);
        end
        win = win_sum[PTR_W-1:0];

        win_we    = 1'b0;
        win_sel   = '0;
        win_idx   = '0;
        win_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PTR_W'(i)) begin
                win_we    = we[i];
                win_sel   = sel[2*i +: 2];
                win_idx   = idx[IDX_W*i +: IDX_W];
                win_wdata = wdata[DATA_W*i +: DATA_W];
            end
        end
        win_legal = (win_idx <= MAX_IDX) && (win_sel != 2'b11);
    end

    // Next-state logic. rf_en/rf_we are computed one cycle early so that the
    // registered strobes are high exactly during ISSUE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        err_d   = err_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rf_en_d = 1'b0;
        rf_we_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d     = win;
                    we_d    = win_we;
                    sel_d   = win_sel;
                    addr_d  = win_idx;
                    wdata_d = win_wdata;
                    if (win_legal) begin
                        state_d = ISSUE;
                        err_d   = 1'b0;
                        rf_en_d = 1'b1;
                        rf_we_d = win_we;
                    end else begin
                        // Rejected: no register-file access, straight to ack.
                        state_d = ACK;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE:   state_d = we_q ? ACK : CAPTURE;
            CAPTURE: begin
                rdata_d = rf_rdata;
                state_d = ACK;
            end
            ACK: begin
                // The granted requester drops to lowest priority, error or not.
                ptr_d   = (g_q == PTR_W'(NREQ-1)) ? '0 : g_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            rf_en_q <= 1'b0;
            rf_we_q <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            err_q   <= err_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            rf_en_q <= rf_en_d;
            rf_we_q <= rf_we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign ack         = (state_q == ACK) ? (NREQ'(1) << g_q) : '0;
    assign err         = (state_q == ACK) && err_q;
    assign rdata       = rdata_q;
    assign rf_en       = rf_en_q;
    assign rf_we       = rf_we_q;
    assign rf_addr_sel = sel_q;
    assign rf_addr     = addr_q;
    assign rf_wdata    = wdata_q;

endmodule
